// File: rtl/uart_pkg.sv
// ---- uart_pkg: shared UART constants and FSM encoding (tx and rx). rev 1.0 ----
`default_nettype none

package uart_pkg;
  localparam int unsigned c_CLK_HZ    = 100_000_000;
  localparam int unsigned c_BAUD_RATE = 9600;
  // Rounded to nearest: 100e6 / 9600 = 10416.67 -> 10417.
  localparam int unsigned c_CLKS_PER_BIT_DEFAULT = (c_CLK_HZ + c_BAUD_RATE / 2) / c_BAUD_RATE;
  localparam int unsigned c_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---- sync_fifo: single-clock FIFO with first-word fall-through read. rev 1.0 ----
`default_nettype none

module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_rd;
  logic                  w_wr;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == c_FULL);
  assign empty   = (r_count == '0);
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ---- uart_tx_buffered: FIFO-buffered 8N1 UART transmitter driving RsTx. rev 1.0 ----
`default_nettype none

module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                tx,
  output logic                busy,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam int c_BIT_W = $clog2(c_DATA_BITS);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [c_BAUD_W-1:0]  r_baud;
  logic [c_BIT_W-1:0]   r_bit;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 r_overflow;
  logic                 w_tx_nxt;
  logic                 w_pop;
  logic                 w_bit_done;
  logic [7:0]           w_rd_data;
  logic                 w_full;
  logic                 w_empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count)
  );

  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_bit_done = (r_baud == c_BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_done) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_done && (r_bit == c_LAST_BIT)) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;

      if ((r_state == ST_IDLE) || (w_state_nxt != r_state) || w_bit_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + c_BAUD_W'(1);
      end

      if (w_pop) begin
        r_shift <= w_rd_data;
      end else if ((r_state == ST_DATA) && w_bit_done) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end

      if (r_state == ST_START) begin
        r_bit <= '0;
      end else if ((r_state == ST_DATA) && w_bit_done) begin
        r_bit <= r_bit + c_BIT_W'(1);
      end

      if (wr_en && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE);
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ---- tb_uart_tx_buffered: randomized self-checking bench with transaction-timing model. rev 1.0 ----
`default_nettype none

module tb_uart_tx_buffered;
  localparam int CPB   = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx;
  logic          busy;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Model: accepted bytes, time of the last pop, and the earliest edge the next pop may occur.
  logic [7:0] m_q [$];
  int         m_edge = 0;
  int         m_next_pop = 0;
  int         m_pop_edge = -1000000;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next_pop = 0;
    m_pop_edge = -1000000;
    m_ovf      = 1'b0;
  endtask

  // One frame occupies FRAME clocks plus one idle clock before the next pop.
  task automatic model_step(input bit wr, input logic [7:0] d);
    bit pop;
    m_edge++;
    if (rst) return;
    pop = (m_q.size() > 0) && (m_edge >= m_next_pop);
    if (pop) begin
      m_byte     = m_q.pop_front();
      m_pop_edge = m_edge;
      m_next_pop = m_edge + FRAME + 1;
    end
    if (wr) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic exp_tx();
    int t;
    int b;
    t = m_edge - m_pop_edge - 1;
    if (t < 0 || t >= FRAME) return 1'b1;
    b = t / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic exp_busy();
    int d;
    d = m_edge - m_pop_edge;
    return (d >= 0) && (d < FRAME);
  endfunction

  task automatic check_all();
    chk("tx",       32'(tx),       32'(exp_tx()));
    chk("busy",     32'(busy),     32'(exp_busy()));
    chk("count",    32'(count),    32'(m_q.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input bit wr, input logic [7:0] d);
    wr_en   = wr;
    wr_data = d;
    @(posedge clk);
    model_step(wr, d);
    @(negedge clk);
    wr_en = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    #1 rst = 1'b1;
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    idle(50);

    // Single byte: line falls two clocks after the write.
    tick(1'b1, 8'h55);
    idle(1);
    chk("lat_e1_high", 32'(tx), 32'd1);
    idle(1);
    chk("lat_e2_low", 32'(tx), 32'd0);
    idle(FRAME + 10);

    // Three consecutive writes; first is popped straight away.
    tick(1'b1, 8'h41);
    tick(1'b1, 8'h42);
    tick(1'b1, 8'h43);
    chk("peak_count", 32'(count), 32'd2);
    idle(3 * (FRAME + 1) + 10);

    // Six back-to-back writes: fifth fills the FIFO, sixth is dropped.
    for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom_range(0, 255)));
    chk("sat_count", 32'(count), 32'(DEPTH));
    chk("sat_full", 32'(full), 32'd1);
    chk("ovf_set", 32'(overflow), 32'd1);
    idle(5 * (FRAME + 1) + 10);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Write on the same edge as a pop while full.
    sync_reset_pulse();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom_range(0, 255)));
    idle(FRAME + 1 - 4);
    chk("full_before_pop", 32'(full), 32'd1);
    tick(1'b1, 8'($urandom_range(0, 255)));
    chk("pop_wr_count", 32'(count), 32'(DEPTH));
    chk("pop_wr_ovf", 32'(overflow), 32'd0);
    idle(5 * (FRAME + 1) + 10);

    // Random traffic at a rate that sometimes outpaces the line.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) tick(1'b1, 8'($urandom_range(0, 255)));
      else tick(1'b0, 8'h00);
    end
    idle(DEPTH * (FRAME + 1) + FRAME + 10);

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    sync_reset_pulse();
    tick(1'b1, a5);
    tick(1'b1, 8'($urandom_range(0, 255)));
    tick(1'b1, 8'($urandom_range(0, 255)));
    idle(17);
    chk("bit3_pre_rst", 32'(tx), 32'(a5[3]));
    chk("queued_pre_rst", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    model_reset();
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(3 * (FRAME + 1) + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
